// File: rtl/imm_encoder_if.sv
// Request/response bundle between the program builder, the immediate
// encoder and instruction memory. The encoder uses the slave side.
interface imm_encoder_if;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_fmt;
    logic [6:0]  in_opcode;
    logic [2:0]  in_funct3;
    logic [4:0]  in_rd;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [31:0] in_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic        out_last;
    logic        out_err;

    modport master (
        output in_valid, in_fmt, in_opcode, in_funct3, in_rd, in_rs1, in_rs2, in_imm,
        output out_ready,
        input  in_ready, out_valid, out_instr, out_last, out_err
    );

    modport slave (
        input  in_valid, in_fmt, in_opcode, in_funct3, in_rd, in_rs1, in_rs2, in_imm,
        input  out_ready,
        output in_ready, out_valid, out_instr, out_last, out_err
    );
endinterface

// File: rtl/imm_encoder.sv
// Registered RV32I immediate encoder: packs an immediate plus register and
// opcode fields into an I/S/B/U/J instruction word, or expands a
// load-immediate into ADDI, LUI or LUI+ADDI.
module imm_encoder (
    input  logic          clk,
    input  logic          rst_n,
    imm_encoder_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_EMIT1,
        S_EMIT2
    } state_t;

    typedef enum logic [2:0] {
        F_I    = 3'd0,
        F_S    = 3'd1,
        F_B    = 3'd2,
        F_U    = 3'd3,
        F_J    = 3'd4,
        F_LI   = 3'd5,
        F_RSV6 = 3'd6,
        F_RSV7 = 3'd7
    } fmt_t;

    localparam logic [6:0] OPC_LUI  = 7'h37;
    localparam logic [6:0] OPC_ADDI = 7'h13;

    state_t      state_q, state_d;
    logic        valid_q, valid_d;
    logic [31:0] instr_q, instr_d;
    logic        last_q,  last_d;
    logic        err_q,   err_d;
    logic [31:0] second_q, second_d;
    logic        pend_q,  pend_d;

    fmt_t        fmt;
    logic [31:0] imm;
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;

    logic        pass;
    logic        two_word;
    logic [31:0] first_word;
    logic [31:0] second_word;
    logic        fits12;
    logic [11:0] lo;
    logic [19:0] hi;

    assign fmt = fmt_t'(bus.in_fmt);
    assign imm = bus.in_imm;
    assign opc = bus.in_opcode;
    assign f3  = bus.in_funct3;
    assign rd  = bus.in_rd;
    assign rs1 = bus.in_rs1;
    assign rs2 = bus.in_rs2;

    assign bus.in_ready  = (state_q == S_IDLE);
    assign bus.out_valid = valid_q;
    assign bus.out_instr = instr_q;
    assign bus.out_last  = last_q;
    assign bus.out_err   = err_q;

    // Range check and pack the request into its first (and optional second) word.
    always_comb begin
        pass        = 1'b0;
        two_word    = 1'b0;
        first_word  = '0;
        second_word = '0;
        fits12      = (imm[31:11] == '0) || (imm[31:11] == '1);
        lo          = imm[11:0];
        // (imm + 0x800) >> 12: the low 11 bits cannot carry, so only imm[11]
        // propagates into the upper field; the 20-bit add wraps like the 32-bit one.
        hi          = imm[31:12] + {19'd0, imm[11]};
        case (fmt)
            F_I: begin
                pass       = fits12;
                first_word = {imm[11:0], rs1, f3, rd, opc};
            end
            F_S: begin
                pass       = fits12;
                first_word = {imm[11:5], rs2, rs1, f3, imm[4:0], opc};
            end
            F_B: begin
                pass       = !imm[0] && ((imm[31:12] == '0) || (imm[31:12] == '1));
                first_word = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], opc};
            end
            F_U: begin
                pass       = (imm[11:0] == '0);
                first_word = {imm[31:12], rd, opc};
            end
            F_J: begin
                pass       = !imm[0] && ((imm[31:20] == '0) || (imm[31:20] == '1));
                first_word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opc};
            end
            F_LI: begin
                pass = 1'b1;
                if (fits12) begin
                    first_word = {lo, 5'd0, 3'd0, rd, OPC_ADDI};
                end else if (lo == '0) begin
                    first_word = {hi, rd, OPC_LUI};
                end else begin
                    two_word    = 1'b1;
                    first_word  = {hi, rd, OPC_LUI};
                    second_word = {lo, rd, 3'd0, rd, OPC_ADDI};
                end
            end
            default: pass = 1'b0;
        endcase
    end

    // Handshake sequencing: accept in IDLE, hold words until the consumer takes them.
    always_comb begin
        state_d  = state_q;
        valid_d  = valid_q;
        instr_d  = instr_q;
        last_d   = last_q;
        err_d    = 1'b0;
        second_d = second_q;
        pend_d   = pend_q;
        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    if (pass) begin
                        instr_d  = first_word;
                        valid_d  = 1'b1;
                        last_d   = !two_word;
                        second_d = second_word;
                        pend_d   = two_word;
                        state_d  = S_EMIT1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_EMIT1: begin
                if (bus.out_ready) begin
                    if (pend_q) begin
                        instr_d = second_q;
                        last_d  = 1'b1;
                        pend_d  = 1'b0;
                        state_d = S_EMIT2;
                    end else begin
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        state_d = S_IDLE;
                    end
                end
            end
            S_EMIT2: begin
                if (bus.out_ready) begin
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                valid_d = 1'b0;
                last_d  = 1'b0;
                pend_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset discards any pending second word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            valid_q  <= 1'b0;
            instr_q  <= '0;
            last_q   <= 1'b0;
            err_q    <= 1'b0;
            second_q <= '0;
            pend_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            valid_q  <= valid_d;
            instr_q  <= instr_d;
            last_q   <= last_d;
            err_q    <= err_d;
            second_q <= second_d;
            pend_q   <= pend_d;
        end
    end

endmodule

// File: tb/tb_imm_encoder.sv
// Self-checking bench for imm_encoder: directed cases from the RV32I encoding
// rules plus randomized requests against an arithmetic reference model.
module tb_imm_encoder;

    logic clk;
    logic rst_n;

    imm_encoder_if bus();

    imm_encoder dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_checks;
    int unsigned n_fail;

    bit [31:0] exp_q[$];
    bit        exp_err;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic drive(input bit [2:0] fmt, input bit [6:0] opc, input bit [2:0] f3,
                         input bit [4:0] rd, input bit [4:0] rs1, input bit [4:0] rs2,
                         input bit [31:0] imm);
        bus.in_fmt    = fmt;
        bus.in_opcode = opc;
        bus.in_funct3 = f3;
        bus.in_rd     = rd;
        bus.in_rs1    = rs1;
        bus.in_rs2    = rs2;
        bus.in_imm    = imm;
    endtask

    // Reference: range checks as signed intervals, packing by shift-and-mask.
    task automatic model(input bit [2:0] fmt, input bit [6:0] opc, input bit [2:0] f3,
                         input bit [4:0] rd, input bit [4:0] rs1, input bit [4:0] rs2,
                         input bit [31:0] imm);
        int        s;
        bit [31:0] o, d, r1, r2, f, w, hi, lo;
        s  = int'(imm);
        o  = 32'(opc);
        d  = 32'(rd) << 7;
        r1 = 32'(rs1) << 15;
        r2 = 32'(rs2) << 20;
        f  = 32'(f3) << 12;
        exp_q.delete();
        exp_err = 1'b0;
        case (fmt)
            3'd0: begin
                exp_err = !(s >= -2048 && s <= 2047);
                w = ((imm & 32'hFFF) << 20) | r1 | f | d | o;
            end
            3'd1: begin
                exp_err = !(s >= -2048 && s <= 2047);
                w = (((imm >> 5) & 32'h7F) << 25) | r2 | r1 | f | ((imm & 32'h1F) << 7) | o;
            end
            3'd2: begin
                exp_err = !((imm % 2) == 0 && s >= -4096 && s <= 4095);
                w = (((imm >> 12) & 1) << 31) | (((imm >> 5) & 32'h3F) << 25) | r2 | r1 | f
                  | (((imm >> 1) & 32'hF) << 8) | (((imm >> 11) & 1) << 7) | o;
            end
            3'd3: begin
                exp_err = (imm % 4096) != 0;
                w = (imm & 32'hFFFFF000) | d | o;
            end
            3'd4: begin
                exp_err = !((imm % 2) == 0 && s >= -(1 << 20) && s < (1 << 20));
                w = (((imm >> 20) & 1) << 31) | (((imm >> 1) & 32'h3FF) << 21)
                  | (((imm >> 11) & 1) << 20) | (((imm >> 12) & 32'hFF) << 12) | d | o;
            end
            3'd5: begin
                lo = imm & 32'hFFF;
                hi = (imm + 32'h800) >> 12;
                if (s >= -2048 && s <= 2047) begin
                    w = (lo << 20) | d | 32'h13;
                end else begin
                    w = (hi << 12) | d | 32'h37;
                    if (lo != 0) exp_q.push_back(w);
                    if (lo != 0) w = (lo << 20) | (32'(rd) << 15) | d | 32'h13;
                end
            end
            default: begin
                exp_err = 1'b1;
                w = 32'h0;
            end
        endcase
        if (!exp_err) exp_q.push_back(w);
    endtask

    // Present the driven request for one edge, then follow every expected word.
    task automatic run_req(input string tag, input int stall);
        check_eq($sformatf("%s:in_ready_pre", tag), bus.in_ready, 1);
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        if (exp_err) begin
            check_eq($sformatf("%s:err", tag), bus.out_err, 1);
            check_eq($sformatf("%s:err_valid", tag), bus.out_valid, 0);
            check_eq($sformatf("%s:err_ready", tag), bus.in_ready, 1);
        end else begin
            check_eq($sformatf("%s:no_err", tag), bus.out_err, 0);
            foreach (exp_q[i]) begin
                check_eq($sformatf("%s:valid%0d", tag, i), bus.out_valid, 1);
                check_eq($sformatf("%s:instr%0d", tag, i), bus.out_instr, exp_q[i]);
                check_eq($sformatf("%s:last%0d", tag, i), bus.out_last, (i == exp_q.size() - 1));
                check_eq($sformatf("%s:busy%0d", tag, i), bus.in_ready, 0);
                for (int k = 0; k < stall; k++) begin
                    bus.out_ready = 1'b0;
                    @(posedge clk); #1;
                    check_eq($sformatf("%s:hold_instr%0d", tag, i), bus.out_instr, exp_q[i]);
                    check_eq($sformatf("%s:hold_last%0d", tag, i), bus.out_last, (i == exp_q.size() - 1));
                    check_eq($sformatf("%s:hold_valid%0d", tag, i), bus.out_valid, 1);
                    check_eq($sformatf("%s:hold_busy%0d", tag, i), bus.in_ready, 0);
                end
                bus.out_ready = 1'b1;
                @(posedge clk); #1;
            end
            check_eq($sformatf("%s:done_valid", tag), bus.out_valid, 0);
            check_eq($sformatf("%s:done_ready", tag), bus.in_ready, 1);
        end
    endtask

    function automatic bit [31:0] rand_imm();
        bit [31:0] edges[7];
        edges = '{32'h000007FF, 32'h00000800, 32'hFFFFF800, 32'hFFFFF7FF,
                  32'h7FFFF800, 32'h7FFFFFFF, 32'h80000000};
        case ($urandom_range(0, 4))
            0:       return 32'($urandom_range(0, 8191)) - 32'd4096;
            1:       return $urandom;
            2:       return $urandom & 32'hFFFFF000;
            3:       return 32'($urandom_range(0, (1 << 21) - 1)) - 32'(1 << 20);
            default: return edges[$urandom_range(0, 6)];
        endcase
    endfunction

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        drive(3'd0, 7'd0, 3'd0, 5'd0, 5'd0, 5'd0, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst:valid", bus.out_valid, 0);
        check_eq("rst:instr", bus.out_instr, 0);
        check_eq("rst:last", bus.out_last, 0);
        check_eq("rst:err", bus.out_err, 0);
        check_eq("rst:in_ready", bus.in_ready, 1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed encodings
        drive(3'd0, 7'h13, 3'd0, 5'd0, 5'd0, 5'd0, 32'hFFFFFF38);
        exp_q = '{32'hF3800013}; exp_err = 1'b0; run_req("I_neg200", 0);
        drive(3'd3, 7'h37, 3'd0, 5'd6, 5'd0, 5'd0, 32'h00064000);
        exp_q = '{32'h00064337}; exp_err = 1'b0; run_req("U", 0);
        drive(3'd2, 7'h63, 3'd0, 5'd0, 5'd6, 5'd0, 32'd12);
        exp_q = '{32'h00030663}; exp_err = 1'b0; run_req("B", 0);
        drive(3'd4, 7'h6F, 3'd0, 5'd6, 5'd0, 5'd0, 32'd8);
        exp_q = '{32'h0080036F}; exp_err = 1'b0; run_req("J", 0);
        drive(3'd5, 7'h00, 3'd0, 5'd5, 5'd0, 5'd0, 32'h12345FFF);
        exp_q = '{32'h123462B7, 32'hFFF28293}; exp_err = 1'b0; run_req("LI_two_stall", 3);
        drive(3'd5, 7'h00, 3'd0, 5'd0, 5'd0, 5'd0, 32'h000007FF);
        exp_q = '{32'h7FF00013}; exp_err = 1'b0; run_req("LI_7ff", 0);
        drive(3'd5, 7'h00, 3'd0, 5'd1, 5'd0, 5'd0, 32'h00001000);
        exp_q = '{32'h000010B7}; exp_err = 1'b0; run_req("LI_lui", 0);
        drive(3'd5, 7'h00, 3'd0, 5'd1, 5'd0, 5'd0, 32'h7FFFF800);
        exp_q = '{32'h800000B7, 32'h80008093}; exp_err = 1'b0; run_req("LI_wrap", 1);

        // Errors, each followed immediately by a good request
        drive(3'd2, 7'h63, 3'd0, 5'd0, 5'd6, 5'd0, 32'd13);
        exp_q.delete(); exp_err = 1'b1; run_req("ERR_B_odd", 0);
        drive(3'd0, 7'h13, 3'd0, 5'd0, 5'd0, 5'd0, 32'hFFFFFF38);
        exp_q = '{32'hF3800013}; exp_err = 1'b0; run_req("after_err1", 0);
        drive(3'd0, 7'h13, 3'd0, 5'd0, 5'd0, 5'd0, 32'd2048);
        exp_q.delete(); exp_err = 1'b1; run_req("ERR_I_2048", 0);
        drive(3'd3, 7'h37, 3'd0, 5'd6, 5'd0, 5'd0, 32'h00064000);
        exp_q = '{32'h00064337}; exp_err = 1'b0; run_req("after_err2", 0);
        drive(3'd7, 7'h13, 3'd0, 5'd0, 5'd0, 5'd0, 32'd0);
        exp_q.delete(); exp_err = 1'b1; run_req("ERR_fmt7", 0);
        drive(3'd4, 7'h6F, 3'd0, 5'd6, 5'd0, 5'd0, 32'd8);
        exp_q = '{32'h0080036F}; exp_err = 1'b0; run_req("after_err3", 0);

        // Reset while the second LI word is pending its handshake
        drive(3'd5, 7'h00, 3'd0, 5'd5, 5'd0, 5'd0, 32'h12345FFF);
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        check_eq("mid_rst:w1", bus.out_instr, 32'h123462B7);
        @(posedge clk); #1;
        check_eq("mid_rst:w2", bus.out_instr, 32'hFFF28293);
        bus.out_ready = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        check_eq("mid_rst:valid", bus.out_valid, 0);
        check_eq("mid_rst:last", bus.out_last, 0);
        check_eq("mid_rst:err", bus.out_err, 0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        check_eq("mid_rst:in_ready", bus.in_ready, 1);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            check_eq("mid_rst:no_stale", bus.out_valid, 0);
        end

        // Randomized requests against the reference model
        for (int n = 0; n < 300; n++) begin
            bit [2:0]  fmt;
            bit [6:0]  opc;
            bit [2:0]  f3;
            bit [4:0]  rd, rs1, rs2;
            bit [31:0] imm;
            fmt = 3'($urandom_range(0, 7));
            opc = 7'($urandom);
            f3  = 3'($urandom);
            rd  = 5'($urandom);
            rs1 = 5'($urandom);
            rs2 = 5'($urandom);
            imm = rand_imm();
            if ($urandom_range(0, 3) == 0) imm = imm & 32'hFFFFFFFE;
            drive(fmt, opc, f3, rd, rs1, rs2, imm);
            model(fmt, opc, f3, rd, rs1, rs2, imm);
            run_req($sformatf("rnd%0d_f%0d_%08h", n, fmt, imm), int'($urandom_range(0, 2)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
